pc_stack_unit: RTL and testbench
================================

# pc_stack_unit

Parametrised program-counter unit for the CE222 processor datapath: holds the fetch address, advances by a fixed instruction step, and applies relative branches, absolute jumps, calls and returns. Calls push the return address onto an internal circular return-address stack (RAS) that returns pop from. It sits in front of instruction memory and replaces the fixed-width, branch-only counter. It adds stall, absolute targets, the RAS and error flags.

## Interface
- PC_W, 16: width of the program counter and of all address ports.
- OFF_W, 21: width of the signed relative branch offset.
- STEP, 4: sequential increment added each non-branch cycle.
- RESET_PC, 0: value loaded into pc on reset.
- DEPTH, 4: RAS entries; must be a power of two, at least 2.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; low forces reset state immediately.
- stall  in  1  hold pc and RAS unchanged this cycle.
- branch  in  1  take relative branch: pc <= pc + sext(offset).
- offset  in  OFF_W  signed two's-complement branch offset.
- jump  in  1  absolute jump: pc <= target.
- call  in  1  push pc+STEP onto RAS, pc <= target.
- ret  in  1  pop RAS top into pc.
- target  in  PC_W  absolute destination for jump/call.
- pc  out  PC_W  current fetch address, registered.
- ras_count  out  $clog2(DEPTH)+1  valid entries, 0..DEPTH.
- ras_empty  out  1  ras_count == 0.
- ras_full  out  1  ras_count == DEPTH.
- ras_ovf  out  1  sticky: a call occurred while full.
- ras_unf  out  1  sticky: a ret occurred while empty.

## Operation
- Per-cycle priority, highest first: stall > ret > call > jump > branch > sequential. Only the winning action takes effect; lower-priority requests in the same cycle are ignored.
- sequential: pc <= pc + STEP.
- branch: offset is sign-extended to PC_W when OFF_W < PC_W and truncated to its low PC_W bits when OFF_W >= PC_W. Sum is taken modulo 2^PC_W.
- jump: pc <= target. The RAS is untouched.
- call: writes (pc + STEP) mod 2^PC_W at the write pointer, advances the write pointer, and sets pc <= target.
  - Not full: ras_count increments.
  - Full: the oldest entry is overwritten (circular), ras_count stays DEPTH, and ras_ovf is set.
- ret: pops the most recently pushed entry into pc, retreats the write pointer and decrements ras_count.
  - Empty: pc <= pc + STEP, pointer and count unchanged, and ras_unf is set.
- Storage is a DEPTH-entry register array with a write pointer of $clog2(DEPTH) bits that wraps modulo DEPTH.
- After an overflow, DEPTH consecutive rets return the DEPTH most recent addresses. The overwritten address is lost.
- ras_ovf and ras_unf are cleared only by reset.
- stall: pc, RAS contents, pointer, count and flags all hold, regardless of other inputs.

## Timing
- Reset (reset low, asynchronous):
  - pc = RESET_PC, ras_count = 0, write pointer = 0.
  - ras_empty = 1, ras_full = 0, ras_ovf = 0, ras_unf = 0.
  - RAS entry contents are don't-care.
- Reset release: the first rising edge with reset high performs a normal update. There is no extra dead cycle.
- Latency: inputs are sampled at a rising edge; the new pc is visible immediately after that edge, one cycle later. No combinational path exists from any input to pc.
- ras_empty, ras_full and ras_count are decoded from registered state and reflect the same edge as pc.
- Sticky flags assert at the edge that performs the offending call or ret.
- Reset asserted mid-cycle or mid-call-sequence discards all RAS contents at once.

## Test plan
Parameters for all scenarios: PC_W=16, OFF_W=21, STEP=4, RESET_PC=0, DEPTH=4.
- Reset then 3 idle cycles -> pc sequence 0, 4, 8, 12; ras_empty=1; all flags 0.
- Branch with pc=0x0010 and offset=-8 -> pc=0x0008. Branch with pc=0xFFFC and offset=+8 -> pc=0x0004 (wrap).
- pc=0x0100, call target=0x0400 -> pc=0x0400, ras_count=1. Then ret -> pc=0x0104, ras_empty=1.
- Five nested calls from pc values 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_ovf=1 after the fifth, ras_count=4. Four rets -> 0x54, 0x44, 0x34, 0x24. A fifth ret -> pc=0x28 and ras_unf=1.
- branch, jump, call and ret all high with a non-empty RAS -> ret wins. The same request held with stall=1 -> pc and ras_count unchanged.
- reset pulsed low asynchronously between edges with ras_count=3 -> pc=0 and ras_count=0 immediately, before the next edge.

Source files
------------

// File: rtl/pc_stack_unit_if.sv
// Request/status bundle between the fetch controller and pc_stack_unit.
// Signal prefixes are given from the unit's point of view.
interface pc_stack_unit_if #(
  parameter int PC_W  = 16,
  parameter int OFF_W = 21,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             i_stall;
  logic             i_branch;
  logic [OFF_W-1:0] i_offset;
  logic             i_jump;
  logic             i_call;
  logic             i_ret;
  logic [PC_W-1:0]  i_target;
  logic [PC_W-1:0]  o_pc;
  logic [CW-1:0]    o_ras_count;
  logic             o_ras_empty;
  logic             o_ras_full;
  logic             o_ras_ovf;
  logic             o_ras_unf;

  modport master (
    output i_stall, i_branch, i_offset, i_jump, i_call, i_ret, i_target,
    input  o_pc, o_ras_count, o_ras_empty, o_ras_full, o_ras_ovf, o_ras_unf
  );

  modport slave (
    input  i_stall, i_branch, i_offset, i_jump, i_call, i_ret, i_target,
    output o_pc, o_ras_count, o_ras_empty, o_ras_full, o_ras_ovf, o_ras_unf
  );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with relative branch, absolute jump and call/return
// through a circular return-address stack that overwrites its oldest entry.
module pc_stack_unit #(
  parameter int          PC_W     = 16,
  parameter int          OFF_W    = 21,
  parameter int          STEP     = 4,
  parameter int unsigned RESET_PC = 0,
  parameter int          DEPTH    = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  pc_stack_unit_if.slave       bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_ras [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [CW-1:0]   r_count;
  logic            r_ovf;
  logic            r_unf;

  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_step;
  logic [AW-1:0]   w_wptr_nxt;
  logic [AW-1:0]   w_top_idx;
  logic [CW-1:0]   w_count_nxt;
  logic            w_ovf_nxt;
  logic            w_unf_nxt;
  logic            w_push;
  logic            w_empty;
  logic            w_full;

  // Signed cast sign-extends a short offset and truncates a wide one.
  function automatic logic [PC_W-1:0] f_offset(input logic [OFF_W-1:0] off);
    return PC_W'($signed(off));
  endfunction

  assign w_pc_step = r_pc + PC_W'(STEP);
  assign w_top_idx = r_wptr - AW'(1);
  assign w_empty   = (r_count == CW'(0));
  assign w_full    = (r_count == CW'(DEPTH));

  // Next-state selection in priority order: stall, ret, call, jump, branch, step.
  always_comb begin
    w_pc_nxt    = r_pc;
    w_wptr_nxt  = r_wptr;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    w_push      = 1'b0;
    if (bus.i_stall) begin
      w_pc_nxt = r_pc;
    end else if (bus.i_ret) begin
      if (w_empty) begin
        w_pc_nxt  = w_pc_step;
        w_unf_nxt = 1'b1;
      end else begin
        w_pc_nxt    = r_ras[w_top_idx];
        w_wptr_nxt  = w_top_idx;
        w_count_nxt = r_count - CW'(1);
      end
    end else if (bus.i_call) begin
      w_push     = 1'b1;
      w_pc_nxt   = bus.i_target;
      w_wptr_nxt = r_wptr + AW'(1);
      if (w_full) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_count_nxt = r_count + CW'(1);
      end
    end else if (bus.i_jump) begin
      w_pc_nxt = bus.i_target;
    end else if (bus.i_branch) begin
      w_pc_nxt = r_pc + f_offset(bus.i_offset);
    end else begin
      w_pc_nxt = w_pc_step;
    end
  end

  // State registers; reset clears the stack so stale return addresses never leak.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pc    <= PC_W'(RESET_PC);
      r_wptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ras[i] <= '0;
      end
    end else begin
      r_pc    <= w_pc_nxt;
      r_wptr  <= w_wptr_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
      if (w_push) begin
        r_ras[r_wptr] <= w_pc_step;
      end
    end
  end

  assign bus.o_pc        = r_pc;
  assign bus.o_ras_count = r_count;
  assign bus.o_ras_empty = w_empty;
  assign bus.o_ras_full  = w_full;
  assign bus.o_ras_ovf   = r_ovf;
  assign bus.o_ras_unf   = r_unf;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Directed self-checking bench for pc_stack_unit with DEPTH=4, STEP=4.
module tb_pc_stack_unit;
  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;

  pc_stack_unit_if #(.PC_W(16), .OFF_W(21), .DEPTH(4)) u_if ();

  pc_stack_unit #(
    .PC_W(16), .OFF_W(21), .STEP(4), .RESET_PC(0), .DEPTH(4)
  ) u_dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    u_if.i_stall  = 1'b0;
    u_if.i_branch = 1'b0;
    u_if.i_offset = 21'h0;
    u_if.i_jump   = 1'b0;
    u_if.i_call   = 1'b0;
    u_if.i_ret    = 1'b0;
    u_if.i_target = 16'h0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_jump(input logic [15:0] t);
    idle_inputs();
    u_if.i_jump = 1'b1; u_if.i_target = t;
    cyc();
    idle_inputs();
  endtask

  task automatic do_call(input logic [15:0] t);
    idle_inputs();
    u_if.i_call = 1'b1; u_if.i_target = t;
    cyc();
    idle_inputs();
  endtask

  task automatic do_ret();
    idle_inputs();
    u_if.i_ret = 1'b1;
    cyc();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #12;
    n_chk++; if (u_if.o_pc !== 16'h0000) $display("FAIL rst_pc got=%h exp=0000", u_if.o_pc); else n_pass++;
    n_chk++; if (u_if.o_ras_count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", u_if.o_ras_count); else n_pass++;
    n_chk++; if (u_if.o_ras_empty !== 1'b1) $display("FAIL rst_empty got=%b exp=1", u_if.o_ras_empty); else n_pass++;
    n_chk++; if ({u_if.o_ras_full, u_if.o_ras_ovf, u_if.o_ras_unf} !== 3'b000)
      $display("FAIL rst_flags got=%b exp=000", {u_if.o_ras_full, u_if.o_ras_ovf, u_if.o_ras_unf}); else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      n_chk++; if (u_if.o_pc !== 16'(4 * i)) $display("FAIL idle_pc%0d got=%h exp=%h", i, u_if.o_pc, 16'(4 * i)); else n_pass++;
    end
    n_chk++; if ({u_if.o_ras_empty, u_if.o_ras_ovf, u_if.o_ras_unf} !== 3'b100)
      $display("FAIL idle_flags got=%b exp=100", {u_if.o_ras_empty, u_if.o_ras_ovf, u_if.o_ras_unf}); else n_pass++;
  endtask

  task automatic test_branch();
    do_jump(16'h0010);
    n_chk++; if (u_if.o_pc !== 16'h0010) $display("FAIL jump_pc got=%h exp=0010", u_if.o_pc); else n_pass++;
    u_if.i_branch = 1'b1; u_if.i_offset = 21'h1FFFF8;
    cyc();
    idle_inputs();
    n_chk++; if (u_if.o_pc !== 16'h0008) $display("FAIL branch_neg got=%h exp=0008", u_if.o_pc); else n_pass++;
    do_jump(16'hFFFC);
    u_if.i_branch = 1'b1; u_if.i_offset = 21'h000008;
    cyc();
    idle_inputs();
    n_chk++; if (u_if.o_pc !== 16'h0004) $display("FAIL branch_wrap got=%h exp=0004", u_if.o_pc); else n_pass++;
    n_chk++; if (u_if.o_ras_count !== 3'd0) $display("FAIL branch_count got=%0d exp=0", u_if.o_ras_count); else n_pass++;
  endtask

  task automatic test_call_ret();
    do_jump(16'h0100);
    do_call(16'h0400);
    n_chk++; if (u_if.o_pc !== 16'h0400) $display("FAIL call_pc got=%h exp=0400", u_if.o_pc); else n_pass++;
    n_chk++; if (u_if.o_ras_count !== 3'd1) $display("FAIL call_count got=%0d exp=1", u_if.o_ras_count); else n_pass++;
    do_ret();
    n_chk++; if (u_if.o_pc !== 16'h0104) $display("FAIL ret_pc got=%h exp=0104", u_if.o_pc); else n_pass++;
    n_chk++; if (u_if.o_ras_empty !== 1'b1) $display("FAIL ret_empty got=%b exp=1", u_if.o_ras_empty); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [15:0] exp_ret [4];
    exp_ret[0] = 16'h0054; exp_ret[1] = 16'h0044; exp_ret[2] = 16'h0034; exp_ret[3] = 16'h0024;
    do_jump(16'h0010);
    do_call(16'h0020);
    do_call(16'h0030);
    do_call(16'h0040);
    do_call(16'h0050);
    n_chk++; if ({u_if.o_ras_full, u_if.o_ras_ovf} !== 2'b10)
      $display("FAIL full_no_ovf got=%b exp=10", {u_if.o_ras_full, u_if.o_ras_ovf}); else n_pass++;
    do_call(16'h0060);
    n_chk++; if (u_if.o_ras_ovf !== 1'b1) $display("FAIL ovf_set got=%b exp=1", u_if.o_ras_ovf); else n_pass++;
    n_chk++; if (u_if.o_ras_count !== 3'd4) $display("FAIL ovf_count got=%0d exp=4", u_if.o_ras_count); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      do_ret();
      n_chk++; if (u_if.o_pc !== exp_ret[i]) $display("FAIL ovf_ret%0d got=%h exp=%h", i, u_if.o_pc, exp_ret[i]); else n_pass++;
    end
    n_chk++; if (u_if.o_ras_unf !== 1'b0) $display("FAIL unf_early got=%b exp=0", u_if.o_ras_unf); else n_pass++;
    do_ret();
    n_chk++; if (u_if.o_pc !== 16'h0028) $display("FAIL unf_pc got=%h exp=0028", u_if.o_pc); else n_pass++;
    n_chk++; if (u_if.o_ras_unf !== 1'b1) $display("FAIL unf_set got=%b exp=1", u_if.o_ras_unf); else n_pass++;
    n_chk++; if (u_if.o_ras_count !== 3'd0) $display("FAIL unf_count got=%0d exp=0", u_if.o_ras_count); else n_pass++;
  endtask

  task automatic test_priority();
    do_jump(16'h0200);
    do_call(16'h0300);
    do_call(16'h0400);
    u_if.i_stall = 1'b1; u_if.i_ret = 1'b1; u_if.i_call = 1'b1; u_if.i_jump = 1'b1;
    u_if.i_branch = 1'b1; u_if.i_offset = 21'h000020; u_if.i_target = 16'h0500;
    cyc();
    n_chk++; if (u_if.o_pc !== 16'h0400) $display("FAIL stall_pc got=%h exp=0400", u_if.o_pc); else n_pass++;
    n_chk++; if (u_if.o_ras_count !== 3'd2) $display("FAIL stall_count got=%0d exp=2", u_if.o_ras_count); else n_pass++;
    u_if.i_stall = 1'b0;
    cyc();
    idle_inputs();
    n_chk++; if (u_if.o_pc !== 16'h0304) $display("FAIL prio_ret_pc got=%h exp=0304", u_if.o_pc); else n_pass++;
    n_chk++; if (u_if.o_ras_count !== 3'd1) $display("FAIL prio_count got=%0d exp=1", u_if.o_ras_count); else n_pass++;
    n_chk++; if ({u_if.o_ras_ovf, u_if.o_ras_unf} !== 2'b11)
      $display("FAIL sticky_hold got=%b exp=11", {u_if.o_ras_ovf, u_if.o_ras_unf}); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_call(16'h0500);
    do_call(16'h0600);
    n_chk++; if (u_if.o_ras_count !== 3'd3) $display("FAIL pre_rst_count got=%0d exp=3", u_if.o_ras_count); else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_chk++; if (u_if.o_pc !== 16'h0000) $display("FAIL async_pc got=%h exp=0000", u_if.o_pc); else n_pass++;
    n_chk++; if (u_if.o_ras_count !== 3'd0) $display("FAIL async_count got=%0d exp=0", u_if.o_ras_count); else n_pass++;
    n_chk++; if ({u_if.o_ras_empty, u_if.o_ras_ovf, u_if.o_ras_unf} !== 3'b100)
      $display("FAIL async_flags got=%b exp=100", {u_if.o_ras_empty, u_if.o_ras_ovf, u_if.o_ras_unf}); else n_pass++;
    #1;
    reset = 1'b1;
    cyc();
    n_chk++; if (u_if.o_pc !== 16'h0004) $display("FAIL post_rst_pc got=%h exp=0004", u_if.o_pc); else n_pass++;
    do_ret();
    n_chk++; if (u_if.o_pc !== 16'h0008) $display("FAIL post_rst_ret got=%h exp=0008", u_if.o_pc); else n_pass++;
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    reset  = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_branch();
    test_call_ret();
    test_overflow();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
